// File: rtl/pc_sequencer_pkg.sv
// Shared opcode constants and sequencer state encoding, so the sequencer and
// the control unit decode from one source.
package pc_sequencer_pkg;

  localparam logic [5:0] OP_JUMP = 6'b000101;
  localparam logic [5:0] OP_BEQ  = 6'b001010;
  localparam logic [5:0] OP_BNE  = 6'b001011;
  localparam logic [5:0] OP_HALT = 6'b011001;

  // Encoding 2'b11 is illegal and recovers to ST_RUN on the next cycle.
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_WAIT_IN = 2'b01,
    ST_STOPPED = 2'b10
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the fetch sequencer and its surroundings: decode inputs from
// the control unit and ALU, the operator button, and the PC/status outputs.
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 10
);
  logic [5:0]          Opcode;
  logic                Desvio;
  logic                TypeJR;
  logic                Halt;
  logic                Zero;
  logic [PC_WIDTH-1:0] Imediato;
  logic [PC_WIDTH-1:0] RegTarget;
  logic                Confirm;
  logic [PC_WIDTH-1:0] PC;
  logic                Running;
  logic                InStrobe;
  logic                Stopped;

  modport master (
    output Opcode, Desvio, TypeJR, Halt, Zero, Imediato, RegTarget, Confirm,
    input  PC, Running, InStrobe, Stopped
  );

  modport slave (
    input  Opcode, Desvio, TypeJR, Halt, Zero, Imediato, RegTarget, Confirm,
    output PC, Running, InStrobe, Stopped
  );
endinterface

// File: rtl/pc_sequencer_confirm_sync.sv
// Synchroniser for the asynchronous Confirm button followed by a registered
// rising-edge detector. The edge register always tracks the level, so holding
// the button yields only one pulse no matter what the consumer is doing.
module pc_sequencer_confirm_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_confirm,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pulse;
  logic                   w_level;

  assign w_level    = r_sync[SYNC_STAGES-1];
  assign rise_pulse = r_pulse;

  // Shift the raw button level through the synchroniser chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_confirm};
    end
  end

  // Remember the previous synchronised level and register the 0->1 transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= w_level;
      r_pulse <= w_level & ~r_prev;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencing ahead of the control unit.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_RUN     | one instruction per cycle, next PC from branch/jump decode
//   ST_WAIT_IN | IN stall, PC held until a synchronised Confirm press
//   ST_STOPPED | HALT executed, PC frozen until reset
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = 10,
  parameter int RESET_PC    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clock,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic                w_rise;
  logic                w_strobe;

  pc_sequencer_confirm_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_confirm_sync (
    .clock      (clock),
    .reset      (reset),
    .i_confirm  (bus.Confirm),
    .rise_pulse (w_rise)
  );

  // Wraps modulo 2^PC_WIDTH without any flag.
  assign w_pc_inc = r_pc + PC_ONE;

  // State and PC registers; reset dominates everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= PC_RST;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Next-state and next-PC selection; HALT beats IN beats any branch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_strobe    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.Opcode == OP_HALT) begin
          w_state_nxt = ST_STOPPED;
        end else if (bus.Halt) begin
          w_state_nxt = ST_WAIT_IN;
        end else if (bus.Desvio) begin
          if (bus.TypeJR) begin
            w_pc_nxt = bus.RegTarget;
          end else if (bus.Opcode == OP_BEQ) begin
            w_pc_nxt = bus.Zero ? bus.Imediato : w_pc_inc;
          end else if (bus.Opcode == OP_BNE) begin
            w_pc_nxt = bus.Zero ? w_pc_inc : bus.Imediato;
          end else begin
            w_pc_nxt = bus.Imediato;
          end
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      ST_WAIT_IN: begin
        // The strobe cycle is still WAIT_IN, so Running stays low while the
        // register file commits the IN data.
        if (w_rise) begin
          w_strobe    = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = ST_RUN;
        end
      end
      ST_STOPPED: begin
        w_state_nxt = ST_STOPPED;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign bus.PC       = r_pc;
  assign bus.Running  = (r_state == ST_RUN);
  assign bus.Stopped  = (r_state == ST_STOPPED);
  assign bus.InStrobe = w_strobe;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int PW     = 10;
  localparam int S      = 2;
  localparam int RST_PC = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pc_sequencer_if #(.PC_WIDTH(PW)) bus();

  pc_sequencer #(
    .PC_WIDTH    (PW),
    .RESET_PC    (RST_PC),
    .SYNC_STAGES (S)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model: mode 0 = running, 1 = waiting for input, 2 = halted.
  int m_pc;
  int m_mode;
  bit samples[S+2];
  bit m_pulse;
  bit chk_en = 1'b0;
  int strobes = 0;
  int last_strobe_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pc_plus1(input int pc);
    return (pc + 1) % (1 << PW);
  endfunction

  // A press is first sampled at one edge and becomes an actionable pulse S
  // edges later; it is only a rising edge if the sample before it was low.
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_pc   = RST_PC;
      m_mode = 0;
      foreach (samples[i]) samples[i] = 1'b0;
      m_pulse = 1'b0;
      chk_en  = 1'b1;
    end else begin
      if (m_mode == 0) begin
        if (bus.Opcode == OP_HALT)               m_mode = 2;
        else if (bus.Halt)                       m_mode = 1;
        else if (bus.Desvio && bus.TypeJR)       m_pc = int'(bus.RegTarget);
        else if (bus.Desvio && bus.Opcode == OP_BEQ)
          m_pc = bus.Zero ? int'(bus.Imediato) : pc_plus1(m_pc);
        else if (bus.Desvio && bus.Opcode == OP_BNE)
          m_pc = !bus.Zero ? int'(bus.Imediato) : pc_plus1(m_pc);
        else if (bus.Desvio)                     m_pc = int'(bus.Imediato);
        else                                     m_pc = pc_plus1(m_pc);
      end else if (m_mode == 1 && m_pulse) begin
        m_pc   = pc_plus1(m_pc);
        m_mode = 0;
      end
      for (int i = S + 1; i > 0; i--) samples[i] = samples[i-1];
      samples[0] = bus.Confirm;
      m_pulse = samples[S] & ~samples[S+1];
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("pc",       bus.PC,       32'(m_pc));
      chk("running",  bus.Running,  32'(m_mode == 0));
      chk("stopped",  bus.Stopped,  32'(m_mode == 2));
      chk("instrobe", bus.InStrobe, 32'(m_mode == 1 && m_pulse));
      if (bus.InStrobe === 1'b1) begin
        strobes++;
        last_strobe_cyc = cyc;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.Opcode    = 6'b000000;
    bus.Desvio    = 1'b0;
    bus.TypeJR    = 1'b0;
    bus.Halt      = 1'b0;
    bus.Zero      = 1'b0;
    bus.Imediato  = '0;
    bus.RegTarget = '0;
  endtask

  task automatic jump_to(input int target);
    bus.Desvio   = 1'b1;
    bus.Opcode   = OP_JUMP;
    bus.Imediato = PW'(target);
    step();
    idle_inputs();
  endtask

  int drive_cyc;
  int s0;
  int r;

  initial begin
    idle_inputs();
    bus.Confirm = 1'b0;
    reset = 1'b1;
    step(2);
    chk("rst_pc", bus.PC, 0);
    chk("rst_running", bus.Running, 1);
    chk("rst_stopped", bus.Stopped, 0);
    chk("rst_strobe", bus.InStrobe, 0);
    reset = 1'b0;

    // Sequential fetch
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("seq_pc", bus.PC, 32'(i));
      chk("seq_running", bus.Running, 1);
    end

    // Conditional branches from PC=3
    jump_to(3);
    bus.Desvio = 1'b1; bus.Opcode = OP_BEQ; bus.Zero = 1'b1; bus.Imediato = PW'(40);
    step(); idle_inputs();
    chk("beq_taken", bus.PC, 40);
    jump_to(3);
    bus.Desvio = 1'b1; bus.Opcode = OP_BEQ; bus.Zero = 1'b0; bus.Imediato = PW'(40);
    step(); idle_inputs();
    chk("beq_not_taken", bus.PC, 4);
    jump_to(3);
    bus.Desvio = 1'b1; bus.Opcode = OP_BNE; bus.Zero = 1'b0; bus.Imediato = PW'(40);
    step(); idle_inputs();
    chk("bne_taken", bus.PC, 40);

    // Jump register and wrap-around
    bus.Desvio = 1'b1; bus.TypeJR = 1'b1; bus.RegTarget = PW'(17); bus.Imediato = PW'(99);
    step(); idle_inputs();
    chk("jr", bus.PC, 17);
    jump_to(1023);
    chk("jump_1023", bus.PC, 1023);
    step();
    chk("wrap", bus.PC, 0);

    // IN stall and Confirm handshake
    jump_to(8);
    bus.Halt = 1'b1;
    step();
    bus.Halt = 1'b0;
    chk("in_pc_held", bus.PC, 8);
    chk("in_running", bus.Running, 0);
    step(3);
    chk("in_pc_still", bus.PC, 8);
    s0 = strobes;
    drive_cyc = cyc;
    bus.Confirm = 1'b1;
    step(S + 1);
    chk("strobe_now", bus.InStrobe, 1);
    chk("strobe_running", bus.Running, 0);
    chk("strobe_pc", bus.PC, 8);
    step();
    chk("after_strobe_pc", bus.PC, 9);
    chk("after_strobe_running", bus.Running, 1);
    step(6);
    chk("single_strobe", 32'(strobes - s0), 1);
    chk("strobe_latency", 32'(last_strobe_cyc - drive_cyc), 32'(S + 1));
    // Button still held: a new IN must not be satisfied by it
    bus.Halt = 1'b1;
    step();
    bus.Halt = 1'b0;
    s0 = strobes;
    step(10);
    chk("held_no_strobe", 32'(strobes - s0), 0);
    chk("held_running", bus.Running, 0);
    bus.Confirm = 1'b0;
    step(3);
    bus.Confirm = 1'b1;
    step(S + 1);
    chk("repress_strobe", bus.InStrobe, 1);
    step();
    chk("repress_running", bus.Running, 1);
    bus.Confirm = 1'b0;

    // HALT freezes everything until reset
    jump_to(12);
    bus.Opcode = OP_HALT;
    step();
    chk("halt_stopped", bus.Stopped, 1);
    chk("halt_pc", bus.PC, 12);
    for (int i = 0; i < 50; i++) begin
      bus.Opcode   = 6'($urandom);
      bus.Desvio   = 1'($urandom);
      bus.Halt     = 1'($urandom);
      bus.Confirm  = 1'($urandom);
      bus.Imediato = PW'($urandom);
      step();
      chk("frozen_pc", bus.PC, 12);
    end
    idle_inputs();
    bus.Confirm = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("halt_reset_pc", bus.PC, 0);
    chk("halt_reset_stopped", bus.Stopped, 0);

    // Reset while waiting, on the cycle Confirm rises
    bus.Halt = 1'b1;
    step();
    bus.Halt = 1'b0;
    step(2);
    s0 = strobes;
    reset = 1'b1;
    bus.Confirm = 1'b1;
    step(2);
    reset = 1'b0;
    step(10);
    chk("rst_wait_no_strobe", 32'(strobes - s0), 0);
    chk("rst_wait_pc", bus.PC, 10);
    chk("rst_wait_running", bus.Running, 1);
    bus.Confirm = 1'b0;
    step(2);

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1)       bus.Opcode = OP_HALT;
      else if (r < 20) bus.Opcode = OP_BEQ;
      else if (r < 38) bus.Opcode = OP_BNE;
      else if (r < 50) bus.Opcode = OP_JUMP;
      else             bus.Opcode = 6'($urandom);
      bus.Desvio    = ($urandom_range(0, 99) < 40);
      bus.TypeJR    = bus.Desvio && ($urandom_range(0, 3) == 0);
      bus.Halt      = ($urandom_range(0, 99) < 6);
      bus.Zero      = 1'($urandom);
      bus.Imediato  = PW'($urandom);
      bus.RegTarget = PW'($urandom);
      if ($urandom_range(0, 99) < 15) bus.Confirm = ~bus.Confirm;
      reset = ($urandom_range(0, 99) < 2);
      step();
    end
    reset = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
